// File: rtl/pipe_pkg.sv
// Shared definitions for the 8-bit IF/ID/EX/WB pipeline: opcodes, instruction
// field positions, datapath defaults and the imm6 sign-extension helper.
package pipe_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 3;
  localparam int DEF_IW = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  function automatic logic [DEF_DW-1:0] sext6(input logic [5:0] imm);
    return {{(DEF_DW-6){imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand source selection and hazard detection for the ID stage.
// With ID_FWD_EN defined, EX/WB results are forwarded; otherwise any RAW match stalls.
module id_fwd_mux
  import pipe_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic [AW-1:0] src,
  input  logic          used,
  input  logic [DW-1:0] rdata,
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_res,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_wa,
  input  logic [DW-1:0] wb_wd,
  output logic [DW-1:0] opnd,
  output logic          hazard
);

  logic live, ex_match, wb_match;

  // r0 is hardwired, so it never participates in a dependency
  assign live     = used && (src != '0);
  assign ex_match = live && ex_valid && ex_we && (ex_rd == src);
  assign wb_match = live && wb_we && (wb_wa == src);

`ifdef ID_FWD_EN
  always_comb begin
    opnd   = rdata;
    hazard = 1'b0;
    if (ex_match && !ex_is_load) opnd = ex_res;
    else if (wb_match)           opnd = wb_wd;
    // load data only exists at WB, so a load in EX must be waited out
    if (ex_match && ex_is_load)  hazard = 1'b1;
  end
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{ex_is_load, ex_res, wb_wd};

  always_comb begin
    opnd   = rdata;
    hazard = ex_match || wb_match;
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// Decode/operand-fetch stage owning the ID/EX register; handles stalls, bubbles and flush.
// Optional operand forwarding is enabled by defining ID_FWD_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int IW = DEF_IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [IW-1:0] id_instr,
  input  logic          flush,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic [DW-1:0] ex_alu_res,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_wa,
  input  logic [DW-1:0] wb_wd,
  output logic          stall_if,
  output logic          ex_valid,
  output logic [3:0]    ex_op,
  output logic [AW-1:0] ex_rd,
  output logic          ex_we,
  output logic          ex_is_load,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b
);

  typedef struct packed {
    logic          valid;
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic          we;
    logic          is_load;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } idex_t;

  idex_t idex_d, idex_q;

  logic [3:0]    op;
  logic [AW-1:0] rd, rs1, rs2;
  logic [5:0]    imm6;
  logic          r_type, i_type, use1, use2, haz1, haz2, bubble;
  logic [DW-1:0] opnd1, opnd2;

  assign op   = id_instr[OP_LSB +: 4];
  assign rd   = id_instr[RD_LSB +: AW];
  assign rs1  = id_instr[RS1_LSB +: AW];
  assign rs2  = id_instr[RS2_LSB +: AW];
  assign imm6 = id_instr[IMM_LSB +: 6];

  assign r_type = (op >= OP_ADD) && (op <= OP_OR);
  assign i_type = (op == OP_ADDI) || (op == OP_LD);
  assign use1   = r_type || i_type;
  assign use2   = r_type;

  assign ra1 = rs1;
  assign ra2 = rs2;

  id_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .src(rs1), .used(use1), .rdata(rd1),
    .ex_valid(idex_q.valid), .ex_we(idex_q.we), .ex_is_load(idex_q.is_load),
    .ex_rd(idex_q.rd), .ex_res(ex_alu_res),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .opnd(opnd1), .hazard(haz1)
  );

  id_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .src(rs2), .used(use2), .rdata(rd2),
    .ex_valid(idex_q.valid), .ex_we(idex_q.we), .ex_is_load(idex_q.is_load),
    .ex_rd(idex_q.rd), .ex_res(ex_alu_res),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .opnd(opnd2), .hazard(haz2)
  );

  // a squashed or absent instruction must never hold the front end
  assign stall_if = !rst && id_valid && !flush && (haz1 || haz2);
  assign bubble   = !id_valid || flush || stall_if;

  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.valid   = 1'b1;
      idex_d.op      = op;
      idex_d.rd      = rd;
      idex_d.we      = use1 && (rd != '0);
      idex_d.is_load = (op == OP_LD);
      idex_d.a       = use1 ? opnd1 : '0;
      if (i_type)      idex_d.b = DW'($signed(sext6(imm6)));
      else if (use2)   idex_d.b = opnd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign ex_valid   = idex_q.valid;
  assign ex_op      = idex_q.op;
  assign ex_rd      = idex_q.rd;
  assign ex_we      = idex_q.we;
  assign ex_is_load = idex_q.is_load;
  assign ex_a       = idex_q.a;
  assign ex_b       = idex_q.b;

endmodule
